// File: rtl/sum_uart_pkg.sv
// Shared types and constants for the summing UART sequencer: FSM states,
// ASCII framing constants and the byte-selection helper.
package sum_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_DONE
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] DEFAULT_EOL = 8'h0D;
  localparam int         FRAME_LEN   = 3;
  localparam logic [1:0] LAST_IDX    = 2'(FRAME_LEN - 1);

  // Frame is two decimal ASCII digits of the snapshot followed by the terminator.
  function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                            input logic [4:0] value,
                                            input logic [7:0] eol);
    logic [4:0] tens;
    logic [4:0] units;
    tens  = value / 5'd10;
    units = value % 5'd10;
    case (idx)
      2'd0:    frame_byte = ASCII_ZERO + {3'b000, tens};
      2'd1:    frame_byte = ASCII_ZERO + {3'b000, units};
      default: frame_byte = eol;
    endcase
  endfunction

endpackage

// File: rtl/sum_uart_sequencer_if.sv
// Bundle of the sequencer's button, operand, UART handshake and status signals.
interface sum_uart_sequencer_if;

  logic       save_a_n;
  logic       save_b_n;
  logic [3:0] data_input;
  logic       uart_tx_en;
  logic       uart_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [4:0] sum_q;
  logic       seq_busy;
  logic       frame_done;
  logic       tx_err;

  modport master (
    output save_a_n, save_b_n, data_input, uart_tx_en, uart_busy,
    input  tx_start, tx_data, a_q, b_q, sum_q, seq_busy, frame_done, tx_err
  );

  modport slave (
    input  save_a_n, save_b_n, data_input, uart_tx_en, uart_busy,
    output tx_start, tx_data, a_q, b_q, sum_q, seq_busy, frame_done, tx_err
  );

endinterface

// File: rtl/sum_uart_sequencer_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input with single-cycle
// rise/fall pulses derived from the synchronized level.
module sync_edge_det #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~prev;
  assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/sum_uart_sequencer.sv
// Captures two 4-bit operands from buttons and, on request, sends their sum
// as two ASCII decimal digits plus a terminator through a byte-wide UART.
module sum_uart_sequencer
  import sum_uart_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         ACK_TIMEOUT = 255,
  parameter logic [7:0] EOL_BYTE    = DEFAULT_EOL
) (
  input logic                 clk,
  input logic                 reset,
  sum_uart_sequencer_if.slave bus
);

  localparam int             TW           = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(ACK_TIMEOUT - 1);

  logic a_fall, b_fall, tx_rise;
  logic unused_a_rise, unused_b_rise, unused_tx_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_a (
    .clk(clk), .reset(reset), .async_in(bus.save_a_n),
    .rise(unused_a_rise), .fall(a_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_b (
    .clk(clk), .reset(reset), .async_in(bus.save_b_n),
    .rise(unused_b_rise), .fall(b_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_tx (
    .clk(clk), .reset(reset), .async_in(bus.uart_tx_en),
    .rise(tx_rise), .fall(unused_tx_fall)
  );

  logic [3:0] a_q, b_q;
  logic       a_valid, b_valid;
  logic [4:0] sum_q;

  // Operand capture runs in every state; the frame works from its own snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      a_valid <= 1'b0;
      b_valid <= 1'b0;
    end else begin
      if (a_fall) begin
        a_q     <= bus.data_input;
        a_valid <= 1'b1;
      end
      if (b_fall) begin
        b_q     <= bus.data_input;
        b_valid <= 1'b1;
      end
    end
  end

  assign sum_q = {1'b0, a_q} + {1'b0, b_q};

  state_t        state, state_next;
  logic [1:0]    idx, idx_next;
  logic [4:0]    snap, snap_next;
  logic [TW-1:0] timer, timer_next;
  logic          tx_err, tx_err_next;
  logic          tx_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      idx    <= 2'd0;
      snap   <= 5'd0;
      timer  <= '0;
      tx_err <= 1'b0;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      snap   <= snap_next;
      timer  <= timer_next;
      tx_err <= tx_err_next;
    end
  end

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    snap_next   = snap;
    timer_next  = timer;
    tx_err_next = tx_err;
    tx_start    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx_rise && a_valid && b_valid) begin
          snap_next   = sum_q;
          idx_next    = 2'd0;
          tx_err_next = 1'b0;
          state_next  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!bus.uart_busy) begin
          tx_start   = 1'b1;
          timer_next = '0;
          state_next = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // A UART that never reports busy aborts the whole frame.
        if (bus.uart_busy) begin
          state_next = ST_WAIT_DONE;
        end else if (timer == TIMEOUT_LAST) begin
          tx_err_next = 1'b1;
          state_next  = ST_IDLE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.uart_busy) begin
          if (idx == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            idx_next   = idx + 2'd1;
            state_next = ST_SEND;
          end
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Byte depends only on idx and snapshot, so it holds steady through each byte.
  assign bus.tx_data    = (state == ST_SEND || state == ST_WAIT_ACK || state == ST_WAIT_DONE)
                          ? frame_byte(idx, snap, EOL_BYTE) : 8'h00;
  assign bus.tx_start   = tx_start;
  assign bus.a_q        = a_q;
  assign bus.b_q        = b_q;
  assign bus.sum_q      = sum_q;
  assign bus.seq_busy   = (state != ST_IDLE);
  assign bus.frame_done = (state == ST_DONE);
  assign bus.tx_err     = tx_err;

endmodule

// File: tb/tb_sum_uart_sequencer.sv
// Randomized and directed checks of sum_uart_sequencer against a small
// arithmetic model of the expected ASCII frames.
module tb_sum_uart_sequencer;

  localparam int ACK_TIMEOUT = 255;
  localparam int BUSY_CYCLES = 10;

  logic clk;
  logic reset;

  sum_uart_sequencer_if bus();

  sum_uart_sequencer #(
    .SYNC_STAGES(2),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .EOL_BYTE(8'h0D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         cycle = 0;
  int         start_count = 0;
  int         done_count = 0;
  int         busy_cycles = 0;
  int         start_cycle = 0;
  logic [7:0] sent_q[$];
  bit         ack_enable = 1'b1;

  int model_a = 0, model_b = 0;
  bit model_a_valid = 1'b0, model_b_valid = 1'b0;

  int frame_sum;
  bit frame_expected;
  int base_sent, base_starts, base_done, base_busy;

  // UART stand-in: goes busy the cycle after each tx_start for BUSY_CYCLES.
  initial begin
    bit pending;
    bit saw_start;
    int cnt;
    pending = 1'b0;
    cnt = 0;
    bus.uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      cycle++;
      saw_start = (bus.tx_start === 1'b1);
      if (saw_start) begin
        sent_q.push_back(bus.tx_data);
        start_count++;
        start_cycle = cycle;
      end
      if (bus.frame_done === 1'b1) done_count++;
      if (bus.seq_busy === 1'b1) busy_cycles++;
      if (pending) begin
        pending = 1'b0;
        if (ack_enable) begin
          bus.uart_busy = 1'b1;
          cnt = BUSY_CYCLES;
        end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.uart_busy = 1'b0;
      end
      if (saw_start) pending = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] expectedByte(input int s, input int i);
    if (i == 0) return 8'(8'h30 + s / 10);
    if (i == 1) return 8'(8'h30 + s % 10);
    return 8'h0D;
  endfunction

  // kind: 0 capture A, 1 capture B, 2 transmit request pulse, 3 capture both
  task automatic applyStimulus(input int kind, input logic [3:0] val);
    case (kind)
      0, 1, 3: begin
        bus.data_input = val;
        if (kind != 1) bus.save_a_n = 1'b0;
        if (kind != 0) bus.save_b_n = 1'b0;
        repeat (4) tick();
        bus.save_a_n = 1'b1;
        bus.save_b_n = 1'b1;
        repeat (4) tick();
        if (kind != 1) begin model_a = int'(val); model_a_valid = 1'b1; end
        if (kind != 0) begin model_b = int'(val); model_b_valid = 1'b1; end
      end
      default: begin
        bus.uart_tx_en = 1'b1;
        repeat (4) tick();
        bus.uart_tx_en = 1'b0;
        repeat (2) tick();
      end
    endcase
  endtask

  task automatic startFrame();
    base_sent      = sent_q.size();
    base_starts    = start_count;
    base_done      = done_count;
    base_busy      = busy_cycles;
    frame_sum      = model_a + model_b;
    frame_expected = model_a_valid && model_b_valid;
    applyStimulus(2, 4'h0);
  endtask

  task automatic waitStarts(input string tag, input int n);
    int k = 0;
    while (start_count < base_starts + n && k < 400) begin
      tick();
      k++;
    end
    checkOutput(tag, 32'(start_count >= base_starts + n), 32'd1);
  endtask

  task automatic finishFrame(input string tag);
    int k = 0;
    logic [31:0] got;
    while (bus.seq_busy !== 1'b0 && k < 400) begin
      tick();
      k++;
    end
    checkOutput({tag, "_idle"}, 32'(bus.seq_busy), 32'd0);
    if (frame_expected) begin
      checkOutput({tag, "_starts"}, 32'(start_count - base_starts), 32'd3);
      checkOutput({tag, "_done"}, 32'(done_count - base_done), 32'd1);
      for (int i = 0; i < 3; i++) begin
        got = (base_sent + i < sent_q.size()) ? 32'(sent_q[base_sent + i]) : 32'hFFFF_FFFF;
        checkOutput($sformatf("%s_byte%0d", tag, i), got, 32'(expectedByte(frame_sum, i)));
      end
      checkOutput({tag, "_err"}, 32'(bus.tx_err), 32'd0);
    end else begin
      checkOutput({tag, "_nostart"}, 32'(start_count - base_starts), 32'd0);
      checkOutput({tag, "_nobusy"}, 32'(busy_cycles - base_busy), 32'd0);
    end
  endtask

  initial begin
    int a, b, k, diff;
    reset = 1'b1;
    bus.save_a_n = 1'b1;
    bus.save_b_n = 1'b1;
    bus.data_input = 4'h0;
    bus.uart_tx_en = 1'b0;
    repeat (3) tick();
    checkOutput("rst_a_q", 32'(bus.a_q), 32'd0);
    checkOutput("rst_sum_q", 32'(bus.sum_q), 32'd0);
    checkOutput("rst_tx_data", 32'(bus.tx_data), 32'd0);
    checkOutput("rst_flags", {28'd0, bus.tx_start, bus.seq_busy, bus.frame_done, bus.tx_err}, 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    $display("[TB] only operand A captured");
    applyStimulus(0, 4'h3);
    startFrame();
    finishFrame("only_a");

    $display("[TB] 7 + 9 with ignored request mid-frame");
    applyStimulus(0, 4'h7);
    applyStimulus(1, 4'h9);
    checkOutput("sum_7_9", 32'(bus.sum_q), 32'd16);
    startFrame();
    waitStarts("a7b9_first", 1);
    applyStimulus(2, 4'h0);
    finishFrame("a7b9");
    repeat (20) tick();
    checkOutput("a7b9_no_requeue", 32'(start_count - base_starts), 32'd3);

    $display("[TB] boundary operands");
    applyStimulus(0, 4'hF);
    applyStimulus(1, 4'hF);
    checkOutput("sum_max", 32'(bus.sum_q), 32'd30);
    startFrame();
    finishFrame("max");
    applyStimulus(3, 4'h0);
    checkOutput("sum_zero", 32'(bus.sum_q), 32'd0);
    startFrame();
    finishFrame("zero");
    applyStimulus(3, 4'h5);
    checkOutput("both_b_q", 32'(bus.b_q), 32'd5);
    checkOutput("both_sum", 32'(bus.sum_q), 32'd10);

    $display("[TB] recapture during a frame");
    applyStimulus(0, 4'h7);
    applyStimulus(1, 4'h9);
    startFrame();
    waitStarts("recap_second", 2);
    applyStimulus(0, 4'h1);
    finishFrame("recap_old");
    startFrame();
    finishFrame("recap_new");

    $display("[TB] random operands");
    for (int n = 0; n < 6; n++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      applyStimulus(0, 4'(a));
      applyStimulus(1, 4'(b));
      checkOutput($sformatf("rand%0d_sum", n), 32'(bus.sum_q), 32'(model_a + model_b));
      startFrame();
      finishFrame($sformatf("rand%0d", n));
    end

    $display("[TB] acknowledge timeout");
    ack_enable = 1'b0;
    startFrame();
    waitStarts("to_start", 1);
    k = 0;
    while (bus.seq_busy !== 1'b0 && k < 600) begin
      tick();
      k++;
    end
    diff = cycle - start_cycle;
    checkOutput("to_idle", 32'(bus.seq_busy), 32'd0);
    checkOutput("to_err", 32'(bus.tx_err), 32'd1);
    checkOutput("to_window", 32'(diff >= ACK_TIMEOUT && diff <= ACK_TIMEOUT + 2), 32'd1);
    checkOutput("to_starts", 32'(start_count - base_starts), 32'd1);
    checkOutput("to_nodone", 32'(done_count - base_done), 32'd0);
    ack_enable = 1'b1;
    startFrame();
    finishFrame("after_to");

    $display("[TB] reset mid-frame");
    startFrame();
    waitStarts("rmf_second", 2);
    k = 0;
    while (bus.uart_busy !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    tick();
    checkOutput("rmf_active", 32'(bus.seq_busy), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rmf_flags", {28'd0, bus.tx_start, bus.seq_busy, bus.frame_done, bus.tx_err}, 32'd0);
    checkOutput("rmf_tx_data", 32'(bus.tx_data), 32'd0);
    checkOutput("rmf_operands", {24'd0, bus.a_q, bus.b_q}, 32'd0);
    checkOutput("rmf_sum", 32'(bus.sum_q), 32'd0);
    model_a = 0;
    model_b = 0;
    model_a_valid = 1'b0;
    model_b_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (40) tick();
    checkOutput("rmf_no_start", 32'(start_count - base_starts), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
